muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative RV32M multiply/divide unit in the EX stage, beside the single-cycle ALU.
//   Accepts one op per start pulse, computes in N iterations, returns one registered result with a done pulse.
//   Holds busy high while working; hazard logic stalls the pipeline on busy.
// PARAMETERS
//   N  32  operand/result width; iteration count (one bit per cycle)
// PORTS
//   clk     in   1   clock, rising edge
//   rst     in   1   asynchronous reset, active-high
//   start   in   1   op request; sampled only in IDLE
//   flush   in   1   pipeline kill; aborts the op in flight, no done
//   op      in   3   funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   a       in   N   rs1 operand (dividend / multiplicand)
//   b       in   N   rs2 operand (divisor / multiplier)
//   busy    out  1   high from the cycle after start is accepted until done
//   done    out  1   one-cycle pulse; result is valid in the same cycle
//   result  out  N   registered result; holds until the next done
// BEHAVIOUR
//   Reset: state=IDLE, busy=0, done=0, result=0, all internal registers 0.
//   FSM: IDLE -> CALC on start&~flush; a, b, op latched; operands replaced by absolute values per signedness;
//     iteration count=0.
//   CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle. After N steps -> FIN.
//   FIN: sign-correct, register result, done=1 next cycle -> IDLE.
//   Latency: start sampled in cycle 0 -> done=1 in cycle N+2. busy=1 in cycles 1..N+1.
//   Throughput: start may be asserted again in the done cycle (state is IDLE).
//   Signedness: MUL/MULH/DIV/REM both signed. MULHSU: a signed, b unsigned. MULHU/DIVU/REMU: unsigned.
//   Mul: 2N-bit product, negated if operand signs differ. MUL = low N bits; MULH/MULHSU/MULHU = high N bits.
//   Div: quotient negated if signs differ. Remainder takes the dividend's sign.
//   Div by zero: DIV/DIVU quotient = all ones; REM/REMU = a.
//   Signed overflow (a=-2^(N-1), b=-1): DIV = -2^(N-1), REM = 0.
//   start while busy: ignored; no queueing.
//   flush: in CALC/FIN -> IDLE next edge; busy=0, no done, result unchanged.
//   flush in IDLE with start: flush wins, start ignored.
//   rst mid-operation: immediate return to reset values; no done.
//   op/a/b may change after acceptance without effect.
// CONFIGURATION
//   MULDIV_EARLY_OUT_EN defined: DIV/DIVU/REM/REMU with b=0, and the DIV/REM signed-overflow case,
//     skip CALC: IDLE -> FIN. done arrives in cycle 2, busy=1 in cycle 1 only.
//   Undefined: every op takes the full N+2 latency. Special-case results are identical either way.
// STRUCTURE
//   muldiv_pkg: op encodings (OP_MUL..OP_REMU), state enum {IDLE, CALC, FIN},
//     constant for the iteration-counter width $clog2(N+1).
//   Add/subtract step reuses the existing RCA adder at N+1 bits; no new sub-module.
//   One FSM always block, one datapath register block.
// TESTING
//   MUL a=7, b=-3 -> done in cycle 34 (N=32), result=0xFFFFFFEB. busy high cycles 1..33.
//   MULH a=0x80000000, b=0x80000000 -> 0x40000000.
//   MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
//   MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
//   DIV a=-7, b=2 -> -3 (0xFFFFFFFD). REM same operands -> -1.
//   DIVU a=100, b=7 -> 14. REMU -> 2.
//   DIV a=5, b=0 -> 0xFFFFFFFF; REM -> 5.
//   DIV a=0x80000000, b=-1 -> 0x80000000; REM -> 0.
//   Latency for the special cases: 2 with the macro, 34 without.
//   flush in cycle 10 of a DIV -> busy=0 from cycle 11, no done, result keeps its old value.
//   start pulsed while busy -> ignored.
//   rst asserted mid-CALC -> outputs at reset values at once.
//   Back-to-back: start asserted in the done cycle -> accepted; second done at cycle 34 relative to it.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   // Iteration counter must reach N-1 for an N-bit datapath.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   localparam int CNT_W = cnt_width(32);

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(parameter int N = 32);

   logic         start;
   logic         flush;
   logic [2:0]   op;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] result;

   modport master (output start, flush, op, a, b, input busy, done, result);
   modport slave  (input start, flush, op, a, b, output busy, done, result);

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-subtract step per cycle.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow bypass the iterations.
import muldiv_pkg::*;

module muldiv_unit #(parameter int N = 32) (
   input logic     clk,
   input logic     rst,
   muldiv_if.slave bus
);

   localparam int            CW   = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [N-1:0]  ONE  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0]  MINV = {1'b1, {(N-1){1'b0}}};

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    op_q, op_d;
   logic          neg_q, neg_d;
   logic          special_q, special_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [N-1:0]  result_q, result_d;
   logic [N-1:0]  acc_q, acc_d, mq_q, mq_d, md_q, md_d;

   logic          is_div_s, a_sgn_s, b_sgn_s, a_neg_s, b_neg_s, div0_s, ovf_s;
   logic [N-1:0]  a_abs_s, b_abs_s;
   logic [N:0]    shift_s, add_x_s, add_y_s;
   logic          add_ci_s;
   logic [N+1:0]  add_sum_s;
   logic [N-1:0]  step_acc_s, step_mq_s, q_fix_s, r_fix_s, fin_s;
   logic [2*N-1:0] prod_fix_s;

   assign is_div_s = bus.op[2];
   assign a_sgn_s  = (bus.op != OP_MULHU) && (bus.op != OP_DIVU) && (bus.op != OP_REMU);
   assign b_sgn_s  = a_sgn_s && (bus.op != OP_MULHSU);
   assign a_neg_s  = a_sgn_s & bus.a[N-1];
   assign b_neg_s  = b_sgn_s & bus.b[N-1];
   assign a_abs_s  = a_neg_s ? (~bus.a + ONE) : bus.a;
   assign b_abs_s  = b_neg_s ? (~bus.b + ONE) : bus.b;
   assign div0_s   = is_div_s && (bus.b == {N{1'b0}});
   assign ovf_s    = is_div_s && b_sgn_s && (bus.a == MINV) && (bus.b == {N{1'b1}});

   // Shared N+1-bit adder: product accumulate or trial subtract of the divisor.
   assign shift_s   = {acc_q, mq_q[N-1]};
   assign add_sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {{(N+1){1'b0}}, add_ci_s};

   // Adder operand selection and the per-iteration datapath update.
   always_comb begin
      add_x_s    = {1'b0, acc_q};
      add_y_s    = {(N+1){1'b0}};
      add_ci_s   = 1'b0;
      step_acc_s = acc_q;
      step_mq_s  = mq_q;
      if (op_q[2]) begin
         add_x_s  = shift_s;
         add_y_s  = ~{1'b0, md_q};
         add_ci_s = 1'b1;
         if (add_sum_s[N+1]) begin
            step_acc_s = add_sum_s[N-1:0];
            step_mq_s  = {mq_q[N-2:0], 1'b1};
         end else begin
            step_acc_s = shift_s[N-1:0];
            step_mq_s  = {mq_q[N-2:0], 1'b0};
         end
      end else begin
         add_y_s    = mq_q[0] ? {1'b0, md_q} : {(N+1){1'b0}};
         step_acc_s = add_sum_s[N:1];
         step_mq_s  = {add_sum_s[0], mq_q[N-1:1]};
      end
   end

   // Sign correction: {acc,mq} is the product, or remainder/quotient for divides.
   assign prod_fix_s = neg_q ? (~{acc_q, mq_q} + {{(2*N-1){1'b0}}, 1'b1}) : {acc_q, mq_q};
   assign q_fix_s    = neg_q ? (~mq_q + ONE) : mq_q;
   assign r_fix_s    = neg_q ? (~acc_q + ONE) : acc_q;

   // Final result selection by the latched opcode.
   always_comb begin
      case (op_q)
         OP_MUL:                     fin_s = prod_fix_s[N-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fin_s = prod_fix_s[2*N-1:N];
         OP_DIV, OP_DIVU:            fin_s = q_fix_s;
         default:                    fin_s = r_fix_s;
      endcase
   end

   // FSM next state, operand capture and result registration.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      neg_d     = neg_q;
      special_d = special_q;
      acc_d     = acc_q;
      mq_d      = mq_q;
      md_d      = md_q;
      done_d    = 1'b0;
      result_d  = result_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.flush) begin
               op_d      = bus.op;
               cnt_d     = {CW{1'b0}};
               special_d = div0_s || ovf_s;
               acc_d     = {N{1'b0}};
               md_d      = is_div_s ? b_abs_s : a_abs_s;
               // Special cases preload the final answer and skip sign correction.
               if (div0_s) begin
                  neg_d = 1'b0;
                  acc_d = bus.a;
                  mq_d  = {N{1'b1}};
               end else if (ovf_s) begin
                  neg_d = 1'b0;
                  mq_d  = MINV;
               end else if (is_div_s) begin
                  neg_d = bus.op[1] ? a_neg_s : (a_neg_s ^ b_neg_s);
                  mq_d  = a_abs_s;
               end else begin
                  neg_d = a_neg_s ^ b_neg_s;
                  mq_d  = b_abs_s;
               end
`ifdef MULDIV_EARLY_OUT_EN
               state_d = (div0_s || ovf_s) ? ST_FIN : ST_CALC;
`else
               state_d = ST_CALC;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (bus.flush) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
               if (!special_q) begin
                  acc_d = step_acc_s;
                  mq_d  = step_mq_s;
               end else begin
                  acc_d = acc_q;
               end
               state_d = (cnt_q == LAST) ? ST_FIN : ST_CALC;
            end
         end
         ST_FIN: begin
            if (bus.flush) begin
               state_d = ST_IDLE;
            end else begin
               result_d = fin_s;
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= {CW{1'b0}};
         op_q      <= 3'b000;
         neg_q     <= 1'b0;
         special_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= {N{1'b0}};
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         neg_q     <= neg_d;
         special_q <= special_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= {N{1'b0}};
         mq_q  <= {N{1'b0}};
         md_q  <= {N{1'b0}};
      end else begin
         acc_q <= acc_d;
         mq_q  <= mq_d;
         md_q  <= md_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, flush/reset scenarios and random ops.
module tb_muldiv_unit;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;
   logic [31:0] exp_prev;

   muldiv_if #(.N(32)) bus ();

   muldiv_unit #(.N(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: RV32M semantics from 64-bit arithmetic.
   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ua, ub, p;
      logic ovf;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = 64'sd0;
      case (op)
         3'b000: begin p = sa * sb; return p[31:0]; end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * ub; return p[63:32]; end
         3'b011: begin p = ua * ub; return p[63:32]; end
         3'b100: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         3'b101: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'b110: begin
            if (b == 32'd0) return a;
            if (ovf) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      if (op[2] && (b == 32'd0)) return 2;
      if ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`endif
      return 34;
   endfunction

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   // Issue one op at #1 after an edge; ends #1 after the edge that closes the done cycle.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int lat_exp, got_lat, busy_bad, hold_bad, spur;
      lat_exp  = ref_latency(op, a, b);
      got_lat  = 0;
      busy_bad = 0;
      hold_bad = 0;
      spur     = (lat_exp > 3) ? $urandom_range(2, lat_exp - 1) : 0;
      bus.start = 1'b1; bus.flush = 1'b0; bus.op = op; bus.a = a; bus.b = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.op = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
      for (int k = 1; k <= 60; k++) begin
         bus.start = (k == spur);
         if (bus.busy !== (k < lat_exp)) busy_bad++;
         if (bus.done === 1'b1) begin
            got_lat = k;
            break;
         end
         if (bus.result !== exp_prev) hold_bad++;
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      check_eq({tag, "/latency"}, 32'(got_lat), 32'(lat_exp));
      check_eq({tag, "/result"}, bus.result, exp);
      check_eq({tag, "/busy_bad"}, 32'(busy_bad), 32'd0);
      check_eq({tag, "/hold_bad"}, 32'(hold_bad), 32'd0);
      exp_prev = exp;
   endtask

   task automatic count_done(input string tag, input int cycles);
      int dn;
      dn = 0;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) dn++;
      end
      check_eq({tag, "/no_done"}, 32'(dn), 32'd0);
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[15];

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      n_pass   = 0;
      n_total  = 0;
      exp_prev = 32'd0;
      vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD};
      vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF};
      vecs[6]  = '{3'b101, 32'd100,        32'd7,          32'd14};
      vecs[7]  = '{3'b111, 32'd100,        32'd7,          32'd2};
      vecs[8]  = '{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF};
      vecs[9]  = '{3'b110, 32'd5,          32'd0,          32'd5};
      vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
      vecs[12] = '{3'b100, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFF};
      vecs[13] = '{3'b101, 32'd9,          32'd0,          32'hFFFF_FFFF};
      vecs[14] = '{3'b111, 32'd9,          32'd0,          32'd9};

      rst = 1'b1;
      bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'b000; bus.a = 32'd0; bus.b = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset/busy", {31'd0, bus.busy}, 32'd0);
      check_eq("reset/done", {31'd0, bus.done}, 32'd0);
      check_eq("reset/result", bus.result, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed cases issued back-to-back in each done cycle.
      foreach (vecs[i]) run_op($sformatf("dir%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      count_done("after_dir", 40);

      // Flush in cycle 10 of a divide.
      bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'd1000; bus.b = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      check_eq("flush/busy", {31'd0, bus.busy}, 32'd0);
      check_eq("flush/done", {31'd0, bus.done}, 32'd0);
      count_done("flush", 40);
      check_eq("flush/result", bus.result, exp_prev);

      // Flush together with start in IDLE.
      bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'b000; bus.a = 32'd3; bus.b = 32'd4;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      check_eq("flush_start/busy", {31'd0, bus.busy}, 32'd0);
      count_done("flush_start", 40);
      check_eq("flush_start/result", bus.result, exp_prev);

      // Asynchronous reset in the middle of CALC.
      bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      check_eq("rst_mid/busy", {31'd0, bus.busy}, 32'd0);
      check_eq("rst_mid/done", {31'd0, bus.done}, 32'd0);
      check_eq("rst_mid/result", bus.result, 32'd0);
      exp_prev = 32'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      count_done("rst_mid", 40);

      // Random ops with occasional idle gaps.
      for (int i = 0; i < 60; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = pick_val();
         rb  = pick_val();
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         run_op($sformatf("rnd%0d_op%0d_%h_%h", i, rop, ra, rb), rop, ra, rb, ref_result(rop, ra, rb));
      end
      count_done("tail", 40);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
